pc_stack_seq: RTL and testbench

- Parametrised next-generation program counter for the downsampling processor's multicycle control path.
- Generalises the fixed 8-bit PC with its fixed 4-phase instruction cycle:
  - configurable address width, phase count and reset vector;
  - internal return-address stack giving CALL/RET;
  - sticky stack error flags;
  - synchronous reset.
- Drives the instruction address to the instruction-memory read path (MBRU ins_in) and exposes its phase counter to the control unit.

---
 rtl/pc_stack_seq.sv | 132 +++++++++++++
 tb/tb_pc_stack_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_seq.sv
// Multicycle program counter with a fixed-length phase counter and an internal
// return-address stack providing CALL/RET, with sticky overflow/underflow flags.
module pc_stack_seq #(
    parameter int unsigned    AW         = 8,
    parameter int unsigned    STEPS      = 4,
    parameter int unsigned    DEPTH      = 4,
    parameter logic [AW-1:0]  RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     finish,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    input  logic [AW-1:0]            C_bus,
    output logic [AW-1:0]            ins_address,
    output logic [$clog2(STEPS)-1:0] phase,
    output logic                     running,
    output logic                     stack_overflow,
    output logic                     stack_underflow
);

    localparam int unsigned PW  = $clog2(STEPS);
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            push;
    logic [AW-1:0]   stack_q [DEPTH];

    logic            last_phase;
    logic            stack_empty;
    logic            stack_full;
    logic [IW-1:0]   top_idx;
    logic [IW-1:0]   wr_idx;

    assign last_phase  = (phase_q == PW'(STEPS - 1));
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SPW'(DEPTH));
    assign top_idx     = IW'(sp_q - 1'b1);
    assign wr_idx      = IW'(sp_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            addr_q  <= RESET_ADDR;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Stack contents need no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[wr_idx] <= addr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!finish) begin
                    phase_d = last_phase ? '0 : phase_q + 1'b1;
                    // Commit: ret > call > load > inc; losers are dropped.
                    if (last_phase) begin
                        if (ret) begin
                            if (stack_empty) begin
                                udf_d = 1'b1;
                            end else begin
                                addr_d = stack_q[top_idx];
                                sp_d   = sp_q - 1'b1;
                            end
                        end else if (call) begin
                            if (stack_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                push   = 1'b1;
                                sp_d   = sp_q + 1'b1;
                                addr_d = C_bus;
                            end
                        end else if (load) begin
                            addr_d = C_bus;
                        end else if (inc) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ins_address     = addr_q;
    assign phase           = phase_q;
    assign running         = (state_q == RUN);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = udf_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Scoreboard bench for pc_stack_seq: a behavioural model queues the expected
// post-edge outputs for every driven cycle; they are compared after the edge.
module tb_pc_stack_seq;

    localparam int unsigned AW    = 8;
    localparam int unsigned STEPS = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = $clog2(STEPS);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          finish = 1'b0;
    logic          load = 1'b0;
    logic          inc = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AW-1:0] c_bus = '0;
    logic [AW-1:0] ins_address;
    logic [PW-1:0] phase;
    logic          running;
    logic          stack_overflow;
    logic          stack_underflow;

    pc_stack_seq #(
        .AW(AW),
        .STEPS(STEPS),
        .DEPTH(DEPTH),
        .RESET_ADDR(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .finish(finish),
        .load(load),
        .inc(inc),
        .call(call),
        .ret(ret),
        .C_bus(c_bus),
        .ins_address(ins_address),
        .phase(phase),
        .running(running),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [PW-1:0] phase;
        logic          run;
        logic          ovf;
        logic          udf;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned failures = 0;

    int unsigned m_addr = 0;
    int unsigned m_phase = 0;
    bit          m_run = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    int unsigned m_stk[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model of the edge about to happen, using the inputs currently driven.
    task automatic model_step();
        if (reset) begin
            m_addr  = 0;
            m_phase = 0;
            m_run   = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_stk.delete();
        end else if (!m_run) begin
            if (enable) m_run = 1'b1;
        end else if (!finish) begin
            if (m_phase == STEPS - 1) begin
                m_phase = 0;
                if (ret) begin
                    if (m_stk.size() == 0) m_udf = 1'b1;
                    else m_addr = m_stk.pop_back();
                end else if (call) begin
                    if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                    else begin
                        m_stk.push_back((m_addr + 1) % (1 << AW));
                        m_addr = int'(c_bus);
                    end
                end else if (load) begin
                    m_addr = int'(c_bus);
                end else if (inc) begin
                    m_addr = (m_addr + 1) % (1 << AW);
                end
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.addr  = AW'(m_addr);
        e.phase = PW'(m_phase);
        e.run   = m_run;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("addr", ins_address, e.addr);
            chk("phase", phase, e.phase);
            chk("running", running, e.run);
            chk("ovf", stack_overflow, e.ovf);
            chk("udf", stack_underflow, e.udf);
        end
    endtask

    task automatic wait_phase(input int unsigned p);
        int unsigned n = 0;
        while (m_phase != p && n < 2 * STEPS) begin
            tick();
            n++;
        end
        if (m_phase != p) chk("wait_phase_timeout", m_phase, p);
    endtask

    task automatic commit_cmd(input bit l, input bit i, input bit c, input bit r,
                              input logic [AW-1:0] bus);
        wait_phase(STEPS - 1);
        load  = l;
        inc   = i;
        call  = c;
        ret   = r;
        c_bus = bus;
        tick();
        load  = 1'b0;
        inc   = 1'b0;
        call  = 1'b0;
        ret   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_addr", ins_address, 8'h00);
        chk("rst_run", running, 1'b0);
        inc = 1'b1;
        tick();
        chk("idle_ignores_inc", ins_address, 8'h00);
        inc = 1'b0;

        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("start_run", running, 1'b1);
        chk("start_phase", phase, 2'd0);

        inc = 1'b1;
        repeat (3) tick();
        chk("pre_commit_addr", ins_address, 8'h00);
        chk("pre_commit_phase", phase, 2'd3);
        tick();
        chk("first_commit", ins_address, 8'h01);
        repeat (8) tick();
        chk("inc_seq", ins_address, 8'h03);
        inc = 1'b0;

        commit_cmd(1, 0, 0, 0, 8'h10);
        commit_cmd(0, 0, 1, 0, 8'h40);
        chk("call_jump", ins_address, 8'h40);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("ret_addr", ins_address, 8'h11);

        commit_cmd(1, 0, 0, 0, 8'hFF);
        commit_cmd(0, 1, 0, 0, 8'h00);
        chk("inc_wrap", ins_address, 8'h00);
        chk("wrap_no_ovf", stack_overflow, 1'b0);
        chk("wrap_no_udf", stack_underflow, 1'b0);

        wait_phase(STEPS - 1);
        inc    = 1'b1;
        finish = 1'b1;
        repeat (10) tick();
        chk("freeze_addr", ins_address, 8'h00);
        chk("freeze_phase", phase, 2'd3);
        finish = 1'b0;
        tick();
        chk("post_freeze_addr", ins_address, 8'h01);
        chk("post_freeze_phase", phase, 2'd0);
        inc = 1'b0;

        commit_cmd(1, 0, 0, 0, 8'h11);
        commit_cmd(0, 0, 1, 0, 8'h50);
        commit_cmd(0, 0, 1, 0, 8'h60);
        commit_cmd(0, 0, 1, 0, 8'h70);
        commit_cmd(0, 0, 1, 0, 8'h80);
        commit_cmd(0, 0, 1, 0, 8'h99);
        chk("ovf_hold", ins_address, 8'h80);
        chk("ovf_flag", stack_overflow, 1'b1);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("ret4", ins_address, 8'h71);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("ret3", ins_address, 8'h61);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("ret2", ins_address, 8'h51);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("ret1", ins_address, 8'h12);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("udf_hold", ins_address, 8'h12);
        chk("udf_flag", stack_underflow, 1'b1);

        commit_cmd(1, 1, 1, 0, 8'h22);
        chk("prio_call", ins_address, 8'h22);
        commit_cmd(0, 0, 1, 1, 8'h55);
        chk("prio_ret", ins_address, 8'h13);
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("prio_no_push", ins_address, 8'h13);

        commit_cmd(0, 0, 1, 0, 8'h30);
        commit_cmd(0, 0, 1, 0, 8'h31);
        wait_phase(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_addr", ins_address, 8'h00);
        chk("rst2_phase", phase, 2'd0);
        chk("rst2_run", running, 1'b0);
        chk("rst2_ovf", stack_overflow, 1'b0);
        chk("rst2_udf", stack_underflow, 1'b0);
        inc = 1'b1;
        repeat (8) tick();
        chk("rst2_idle_addr", ins_address, 8'h00);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (4) tick();
        chk("restart_inc", ins_address, 8'h01);
        inc = 1'b0;
        commit_cmd(0, 0, 0, 1, 8'h00);
        chk("rst2_stack_empty", stack_underflow, 1'b1);
        chk("rst2_ret_hold", ins_address, 8'h01);

        if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
